// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared state type, width helpers and header field extraction
package noc_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  function automatic int dest_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int flit_w(input int width);
    return width - 1;
  endfunction

  // Fields come from a zero-extended flit so one helper serves every flit width.
  function automatic logic [31:0] hdr_dest(input logic [31:0] flit, input int dw);
    return flit & ((32'd1 << dw) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] flit, input int fw, input int lw);
    return (flit >> (fw - lw)) & ((32'd1 << lw) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head-visible read data and same-cycle push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && !empty;
  // A pop frees the slot a full-FIFO push lands in, so the count is unchanged.
  assign do_wr   = wr_en && (!full || do_rd);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xbar_input_port.sv
// rtl/xbar_input_port.sv - per-port crossbar injection: buffer, decode header, request, stream packet
module xbar_input_port
  import noc_pkg::*;
#(
  parameter  int PORTS    = 4,
  parameter  int WIDTH    = 8,
  parameter  int BP_WIDTH = 1,
  parameter  int DEPTH    = 8,
  parameter  int LEN_W    = 3,
  localparam int DEST_W   = dest_w(PORTS),
  localparam int FLIT_W   = flit_w(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [WIDTH-1:0]    data_o,
  output logic [DEST_W-1:0]   dest,
  output logic                dest_en,
  input  logic                ack,
  input  logic [BP_WIDTH-1:0] bp_i
);

  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic              hdr_done, hdr_done_n;
  logic [DEST_W-1:0] dest_n;
  logic              dest_en_n;
  logic [WIDTH-1:0]  data_n;
  logic [FLIT_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              tail;

  sync_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (src_valid && src_ready),
    .wr_data (src_data),
    .rd_en   (xfer),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign src_ready = !fifo_full;
  assign xfer      = (state == SEND) && ack && bp_i[0] && !fifo_empty;
  // rem counts payload flits still owed; a header-only packet ends on the header itself.
  assign tail      = xfer && (hdr_done ? (rem == LEN_W'(1)) : (rem == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      hdr_done <= 1'b0;
      dest     <= '0;
      dest_en  <= 1'b0;
      data_o   <= '0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      hdr_done <= hdr_done_n;
      dest     <= dest_n;
      dest_en  <= dest_en_n;
      data_o   <= data_n;
    end
  end

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    hdr_done_n = hdr_done;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n    = REQ;
          rem_n      = LEN_W'(hdr_len(32'(head), FLIT_W, LEN_W));
          hdr_done_n = 1'b0;
        end
      end
      REQ: begin
        if (ack) state_n = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (tail) state_n = IDLE;
          if (hdr_done && (rem != '0)) rem_n = rem - LEN_W'(1);
          hdr_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Releasing into IDLE forces at least one low dest_en cycle before the next request.
  always_comb begin
    dest_n = dest;
    if ((state == IDLE) && !fifo_empty) dest_n = DEST_W'(hdr_dest(32'(head), DEST_W));
    dest_en_n = (state_n != IDLE);
    data_n    = xfer ? {1'b1, head} : '0;
  end

endmodule

// File: tb/tb_xbar_input_port.sv
// tb/tb_xbar_input_port.sv - directed vector table, corner sequences and randomized scoreboard
module tb_xbar_input_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] data_o;
  logic [1:0] dest;
  logic       dest_en;
  logic       ack;
  logic [0:0] bp_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbar_input_port #(.PORTS(4), .WIDTH(8), .BP_WIDTH(1), .DEPTH(8), .LEN_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .data_o    (data_o),
    .dest      (dest),
    .dest_en   (dest_en),
    .ack       (ack),
    .bp_i      (bp_i)
  );

  typedef struct {
    string      name;
    logic       r;
    logic       sv;
    logic [6:0] sd;
    logic       a;
    logic       b;
    logic       x_en;
    logic [1:0] x_dest;
    logic [7:0] x_data;
    logic       x_rdy;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dest;
    logic       tail;
  } exp_t;

  vec_t       vq[$];
  exp_t       exp_q[$];
  logic [6:0] src_q[$];

  task automatic add(input string n, input logic r, input logic sv, input logic [6:0] sd,
                     input logic a, input logic b, input logic x_en, input logic [1:0] xd,
                     input logic [7:0] xdat, input logic xr);
    vec_t v;
    v.name = n; v.r = r; v.sv = sv; v.sd = sd; v.a = a; v.b = b;
    v.x_en = x_en; v.x_dest = xd; v.x_data = xdat; v.x_rdy = xr;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic sv, input logic [6:0] sd, input logic a, input logic b);
    @(negedge clk);
    rst = r; src_valid = sv; src_data = sd; ack = a; bp_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic en, input logic [1:0] d,
                            input logic [7:0] dat, input logic rdy);
    check({nm, "_dest_en"}, dest_en, en);
    check({nm, "_dest"}, dest, d);
    check({nm, "_data"}, data_o, dat);
    check({nm, "_src_ready"}, src_ready, rdy);
  endtask

  int unsigned d, l, mid, f, n;
  logic [6:0]  h;
  logic        prev_go, acc;
  exp_t        e;

  initial begin
    rst = 1'b1; src_valid = 1'b0; src_data = '0; ack = 1'b0; bp_i = 1'b1;

    //       name     rst sv  sd     ack bp  en dest data   rdy
    add("reset",   1, 0, 7'h00, 0, 1, 0, 0, 8'h00, 1);
    add("reset",   1, 0, 7'h00, 0, 1, 0, 0, 8'h00, 1);
    // dest=2 len=2 header, ack one cycle after dest_en
    add("single0", 0, 1, 7'h2E, 0, 1, 0, 0, 8'h00, 1);
    add("single1", 0, 1, 7'h11, 0, 1, 1, 2, 8'h00, 1);
    add("single2", 0, 1, 7'h22, 1, 1, 1, 2, 8'h00, 1);
    add("single3", 0, 0, 7'h00, 1, 1, 1, 2, 8'hAE, 1);
    add("single4", 0, 0, 7'h00, 1, 1, 1, 2, 8'h91, 1);
    add("single5", 0, 0, 7'h00, 1, 1, 0, 2, 8'hA2, 1);
    add("single6", 0, 0, 7'h00, 0, 1, 0, 2, 8'h00, 1);
    // grant withheld five cycles, header must stay in FIFO
    add("grant0",  0, 1, 7'h15, 0, 1, 0, 2, 8'h00, 1);
    add("grant1",  0, 1, 7'h3C, 0, 1, 1, 1, 8'h00, 1);
    for (int i = 0; i < 5; i++) add("grant_wait", 0, 0, 7'h00, 0, 1, 1, 1, 8'h00, 1);
    add("grant_ack", 0, 0, 7'h00, 1, 1, 1, 1, 8'h00, 1);
    add("grant_hdr", 0, 0, 7'h00, 1, 1, 1, 1, 8'h95, 1);
    add("grant_pay", 0, 0, 7'h00, 1, 1, 0, 1, 8'hBC, 1);
    add("grant_end", 0, 0, 7'h00, 0, 1, 0, 1, 8'h00, 1);
    // back-to-back header-only packets to dest 1 then 3
    add("b2b0", 0, 1, 7'h01, 0, 1, 0, 1, 8'h00, 1);
    add("b2b1", 0, 1, 7'h03, 0, 1, 1, 1, 8'h00, 1);
    add("b2b2", 0, 0, 7'h00, 1, 1, 1, 1, 8'h00, 1);
    add("b2b3", 0, 0, 7'h00, 1, 1, 0, 1, 8'h81, 1);
    add("b2b4", 0, 0, 7'h00, 0, 1, 1, 3, 8'h00, 1);
    add("b2b5", 0, 0, 7'h00, 1, 1, 1, 3, 8'h00, 1);
    add("b2b6", 0, 0, 7'h00, 1, 1, 0, 3, 8'h83, 1);
    add("b2b7", 0, 0, 7'h00, 0, 1, 0, 3, 8'h00, 1);
    // three cycles of backpressure after the header
    add("bp0", 0, 1, 7'h30, 0, 1, 0, 3, 8'h00, 1);
    add("bp1", 0, 1, 7'h01, 0, 1, 1, 0, 8'h00, 1);
    add("bp2", 0, 1, 7'h02, 1, 1, 1, 0, 8'h00, 1);
    add("bp3", 0, 1, 7'h03, 1, 1, 1, 0, 8'hB0, 1);
    for (int i = 0; i < 3; i++) add("bp_stall", 0, 0, 7'h00, 1, 0, 1, 0, 8'h00, 1);
    add("bp7",  0, 0, 7'h00, 1, 1, 1, 0, 8'h81, 1);
    add("bp8",  0, 0, 7'h00, 1, 1, 1, 0, 8'h82, 1);
    add("bp9",  0, 0, 7'h00, 1, 1, 0, 0, 8'h83, 1);
    add("bp10", 0, 0, 7'h00, 0, 1, 0, 0, 8'h00, 1);

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].sv, vq[i].sd, vq[i].a, vq[i].b);
      expect_out(vq[i].name, vq[i].x_en, vq[i].x_dest, vq[i].x_data, vq[i].x_rdy);
    end

    // FIFO full: 8 flits accepted with no grant, 9th waits for the first pop
    for (int i = 0; i < 8; i++) begin
      h = (i == 0) ? 7'h72 : 7'(i);
      cyc(0, 1, h, 0, 1);
      check("full_src_ready", src_ready, (i != 7));
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 7'h01, 0, 1);
      expect_out("full_hold", 1, 2, 8'h00, 0);
    end
    cyc(0, 1, 7'h01, 1, 1);
    expect_out("full_ack", 1, 2, 8'h00, 0);
    cyc(0, 1, 7'h01, 1, 1);
    expect_out("full_pop", 1, 2, 8'hF2, 1);
    cyc(0, 1, 7'h01, 1, 1);
    expect_out("full_ninth", 1, 2, 8'h81, 1);
    for (int k = 2; k < 8; k++) begin
      cyc(0, 0, 7'h00, 1, 1);
      expect_out("full_drain", (k != 7), 2, 8'h80 | 8'(k), 1);
    end
    cyc(0, 0, 7'h00, 0, 1);
    expect_out("full_next_req", 1, 1, 8'h00, 1);
    cyc(0, 0, 7'h00, 1, 1);
    expect_out("full_next_ack", 1, 1, 8'h00, 1);
    cyc(0, 0, 7'h00, 1, 1);
    expect_out("full_next_hdr", 0, 1, 8'h81, 1);
    cyc(0, 0, 7'h00, 0, 1);
    expect_out("full_idle", 0, 1, 8'h00, 1);

    // reset after the first of three flits, then a fresh packet
    cyc(0, 1, 7'h23, 0, 1);
    cyc(0, 1, 7'h0A, 0, 1);
    expect_out("rstmid_req", 1, 3, 8'h00, 1);
    cyc(0, 1, 7'h0B, 1, 1);
    cyc(0, 0, 7'h00, 1, 1);
    expect_out("rstmid_hdr", 1, 3, 8'hA3, 1);
    cyc(1, 0, 7'h00, 1, 1);
    expect_out("rstmid_clear", 0, 0, 8'h00, 1);
    cyc(0, 1, 7'h02, 0, 1);
    expect_out("rstmid_fresh0", 0, 0, 8'h00, 1);
    cyc(0, 0, 7'h00, 0, 1);
    expect_out("rstmid_fresh_req", 1, 2, 8'h00, 1);
    cyc(0, 0, 7'h00, 1, 1);
    cyc(0, 0, 7'h00, 1, 1);
    expect_out("rstmid_fresh_hdr", 0, 2, 8'h82, 1);
    cyc(0, 0, 7'h00, 0, 1);
    expect_out("rstmid_idle", 0, 2, 8'h00, 1);

    // randomized traffic against an ordered-stream scoreboard
    for (int p = 0; p < 40; p++) begin
      d   = $urandom_range(0, 3);
      l   = $urandom_range(0, 7);
      mid = $urandom_range(0, 3);
      h   = {l[2:0], mid[1:0], d[1:0]};
      src_q.push_back(h);
      e.data = {1'b1, h}; e.dest = d[1:0]; e.tail = (l == 0);
      exp_q.push_back(e);
      for (int k = 1; k <= int'(l); k++) begin
        f = $urandom_range(0, 127);
        src_q.push_back(f[6:0]);
        e.data = {1'b1, f[6:0]}; e.dest = d[1:0]; e.tail = (k == int'(l));
        exp_q.push_back(e);
      end
    end

    prev_go = 1'b0; acc = 1'b0; n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(negedge clk);
      n++;
      if (acc) void'(src_q.pop_front());
      if (data_o[7]) begin
        e = exp_q.pop_front();
        check("rnd_granted_and_ready", prev_go, 1);
        check("rnd_data", data_o, e.data);
        check("rnd_dest", dest, e.dest);
        check("rnd_dest_en_vs_tail", dest_en, !e.tail);
      end else begin
        check("rnd_idle_data", data_o, 0);
      end
      ack       = dest_en && (ack ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0));
      bp_i[0]   = ($urandom_range(0, 3) != 0);
      src_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
      src_data  = (src_q.size() > 0) ? src_q[0] : 7'h00;
      acc       = src_valid && src_ready;
      prev_go   = ack && bp_i[0];
    end
    check("rnd_all_flits_delivered", exp_q.size(), 0);

    src_valid = 1'b0; ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rnd_no_extra_flit", data_o[7], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbar_input_port.md
Name: xbar_input_port

Overview:
- Per-port injection front end for crossbar_rr; one instance per crossbar input.
- Buffers packets arriving from the local source.
- Decodes the destination from each header flit and drives the crossbar request pair (dest/dest_en).
- After ack, streams the packet's flits into the crossbar under downstream backpressure, then releases the request.

Parameters:
PORTS, 4, number of crossbar ports; sets DEST_W = $clog2(PORTS)
WIDTH, 8, crossbar data width; bit WIDTH-1 is the flit-valid bit, bits WIDTH-2:0 are the flit (FLIT_W = WIDTH-1)
BP_WIDTH, 1, backpressure width; bit 0 = downstream ready (1 = ready), other bits ignored
DEPTH, 8, input FIFO depth in flits, power of two, >= 2
LEN_W, 3, width of the payload-length field in the header

Ports:
clk  in  1  clock
rst  in  1  reset
src_data  in  FLIT_W  flit from local source
src_valid  in  1  source flit valid
src_ready  out  1  FIFO not full
data_o  out  WIDTH  to crossbar data_i[n]; {valid, flit}
dest  out  DEST_W  to crossbar dest[n]
dest_en  out  1  to crossbar dest_en[n]; request held until packet done
ack  in  1  from crossbar ack[n]; grant held while dest_en stays high
bp_i  in  BP_WIDTH  from crossbar bp_o[n]; backpressure of granted output

Behaviour:
- Clock, reset, and FIFO:
  - Single clock clk.
  - Synchronous active-high reset rst.
  - All outputs registered except src_ready (= !fifo_full).
  - Reset values: dest_en=0, dest=0, data_o=0, src_ready=1 the cycle after reset releases, FIFO empty, FSM=IDLE, counter=0.
  - FIFO write when src_valid && src_ready. A write into a full FIFO is impossible; src_ready is 0.
  - Simultaneous read and write when full is permitted and keeps count.
- Packet format:
  - Header flit: dest = flit[DEST_W-1:0], len = flit[FLIT_W-1 -: LEN_W].
  - len payload flits follow; len=0 means header only.
  - The header is forwarded unchanged.
- FSM IDLE:
  - dest_en=0, data_o valid bit 0.
  - If FIFO not empty: latch dest from the head, load rem=len, go to REQ.
  - dest_en rises 1 cycle after the header reaches the FIFO head.
- FSM REQ:
  - dest_en=1, dest stable.
  - On ack=1, go to SEND. No flit moves in the ack-arrival cycle.
- FSM SEND:
  - Transfer condition each cycle: ack && bp_i[0] && !empty.
  - On transfer: pop the head; next cycle data_o = {1'b1, flit}.
  - On no transfer: data_o valid bit = 0 next cycle, flit bits don't-care (driven 0).
  - First transfer is the header; then rem decrements per payload transfer.
  - When the transfer with rem==0 after the header occurs (the tail): dest_en=0 next cycle, go to IDLE.
  - A new request may not be raised in the same cycle as the release. IDLE re-evaluates the head one cycle later, giving a minimum 1-cycle dest_en low gap between packets, which the round-robin arbiter needs to advance.
- Boundary conditions:
  - FIFO empty mid-packet (source slower than crossbar): stall, keep dest_en=1 and hold the grant.
  - bp_i[0]=0: stall, same as above.
  - ack drops while in SEND (protocol violation): treat as a stall, hold state and dest_en. The bench flags it.
  - rem counter is LEN_W bits and never wraps; decrement happens only when rem>0.
  - rst mid-packet: FIFO and FSM clear immediately, dest_en=0 the next cycle, partial packet discarded.
- Throughput: 1 flit/cycle sustained in SEND. Request-to-first-flit latency is 1 cycle after ack.

Decomposition:
- Package noc_pkg: DEST_W/FLIT_W helper functions; header field extraction functions (hdr_dest, hdr_len); state enum typedef {IDLE, REQ, SEND}.
- Sub-module sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop), instantiated once.
- FSM and counter live in xbar_input_port.

Test Plan:
- Single packet, PORTS=4: header 8'h?? with dest=2, len=2, plus payloads 7'h11, 7'h22; ack one cycle after dest_en, bp=1 → dest=2, dest_en high until the cycle after the tail; data_o = 8'h80|hdr, 8'h91, 8'hA2 on consecutive cycles; dest_en then 0.
- Grant delay: hold ack=0 for 5 cycles → dest_en stays 1, data_o valid stays 0, no FIFO pop; first flit appears the cycle after ack rises.
- Backpressure: bp_i=0 for 3 cycles after the header → output valid gaps exactly 3 cycles, no flit lost or duplicated, order preserved.
- Back-to-back packets to dest 1 then dest 3 (len=0 each) → two dest_en pulses separated by exactly 1 low cycle; dest switches 1→3.
- FIFO full: DEPTH=8, ack=0, push 9 flits → src_ready=0 after 8 accepted; the 9th is held by the source, then accepted the cycle after the first pop.
- Reset mid-packet: assert rst during SEND after 1 of 3 flits → next cycle dest_en=0, data_o=0, src_ready=1; a subsequent fresh packet routes correctly.
